denorm: RTL and testbench

Multi-cycle right-shift unit that re-inserts leading zeros into a 32-bit operand. It shifts by a count in the 0..32 range, the same range and encoding the leading-zero counter produces. It sits in the ALU next to the leading-zero counter, which supplies normalisation shift counts. This block applies the inverse shift to denormalise operands or re-align results, and reports a sticky bit for rounding. It is nibble-stepped to keep area small and trades latency for a narrow datapath.

---
 rtl/denorm.sv | 63 ++++++
 tb/tb_denorm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/denorm.sv
// denorm: nibble-stepped right shifter that re-inserts leading zeros and reports a sticky bit.
// Define DENORM_ARITH_EN to make arith=1 request sign fill (arithmetic shift right).
module denorm (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [5:0]  n,
   input  logic        arith,
   output logic [31:0] c,
   output logic        sticky,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t     state;
   logic [5:0] rem;
   logic       fill;
   logic       accept;
   assign accept = start && state == IDLE && !busy;
`ifdef DENORM_ARITH_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) fill <= 1'b0;
      else if (accept) fill <= arith & a[31];
`else
   logic unused_arith;
   assign unused_arith = arith;
   assign fill = 1'b0;
`endif
   // busy trails DONE by one cycle so the earliest restart is the first settled IDLE cycle
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state  <= IDLE;
         rem    <= 6'd0;
         c      <= 32'd0;
         sticky <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= state == DONE;
         busy <= accept || state != IDLE;
         case (state)
            IDLE:
               if (accept) begin
                  c      <= a;
                  rem    <= n > 6'd32 ? 6'd32 : n;
                  sticky <= 1'b0;
                  state  <= SHIFT;
               end
            SHIFT:
               if (rem >= 6'd4) begin
                  c      <= {{4{fill}}, c[31:4]};
                  sticky <= sticky | (|c[3:0]);
                  rem    <= rem - 6'd4;
               end else if (rem != 6'd0) begin
                  c      <= {fill, c[31:1]};
                  sticky <= sticky | c[0];
                  rem    <= rem - 6'd1;
               end else state <= DONE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_denorm.sv
// tb_denorm: scoreboard bench for denorm; expectations come from a bit-serial reference model.
module tb_denorm;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = 32'd0;
   logic [5:0]  n = 6'd0;
   logic        arith = 1'b0;
   logic [31:0] c;
   logic        sticky, busy, done;
   denorm dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .n(n), .arith(arith),
      .c(c), .sticky(sticky), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
`ifdef DENORM_ARITH_EN
   localparam bit ARITH = 1'b1;
`else
   localparam bit ARITH = 1'b0;
`endif
   typedef struct {
      logic [31:0] c;
      logic        s;
      int          due;
   } exp_t;
   exp_t q[$];
   int edges = 0;
   int checks = 0;
   int failures = 0;
   int fall_due = 0;
   always @(posedge clk) edges++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask
   // reference: one bit per step, latency from the nibble/bit step count
   function automatic exp_t model(input logic [31:0] av, input logic [5:0] nv, input logic ar, input int acc);
      exp_t e;
      int   nn;
      logic f;
      nn = nv > 32 ? 32 : int'(nv);
      f = ARITH & ar & av[31];
      e.c = av;
      e.s = 1'b0;
      for (int i = 0; i < nn; i++) begin
         e.s = e.s | e.c[0];
         e.c = {f, e.c[31:1]};
      end
      e.due = acc + 2 + nn / 4 + nn % 4;
      return e;
   endfunction
   always @(negedge clk)
      if (!reset && done) begin
         if (q.size() == 0) check("spurious_done", {31'd0, done}, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("c", c, e.c);
            check("sticky", {31'd0, sticky}, {31'd0, e.s});
            check("done_edge", edges, e.due);
         end
      end
   // called at a negedge; returns at the negedge after the accepting edge
   task automatic go(input logic [31:0] av, input logic [5:0] nv, input logic ar);
      exp_t e;
      e = model(av, nv, ar, edges + 1);
      q.push_back(e);
      fall_due = e.due + 1;
      a = av;
      n = nv;
      arith = ar;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_rise", {31'd0, busy}, 32'd1);
   endtask
   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 60) begin
         @(negedge clk);
         k++;
      end
      check("busy_fall_edge", busy ? 32'hffffffff : edges, fall_due);
   endtask
   logic [31:0] ra;
   logic [5:0]  rn;
   int acc;
   initial begin
      @(negedge clk);
      check("rst_c", c, 32'd0);
      check("rst_flags", {28'd0, sticky, busy, done, 1'b0}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      go(32'h80000000, 6'd31, 1'b0); wait_idle();
      go(32'hFFFFFFFF, 6'd4, 1'b0);  wait_idle();
      go(32'h12345678, 6'd0, 1'b0);  wait_idle();
      go(32'h12345678, 6'd40, 1'b0); wait_idle();
      go(32'h0000000F, 6'd7, 1'b0);  wait_idle();
      go(32'h80000000, 6'd4, 1'b1);  wait_idle();
      go(32'h80000001, 6'd32, 1'b1); wait_idle();
      go(32'hC0000003, 6'd63, 1'b1); wait_idle();
      // starts during SHIFT and DONE must be dropped
      acc = edges;
      go(32'h00000001, 6'd32, 1'b0);
      while (edges < acc + 2) @(negedge clk);
      a = 32'hFFFFFFFF; start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (edges < acc + 9) @(negedge clk);
      a = 32'hFFFFFFFF; n = 6'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("ignored_start_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rn = 6'($urandom_range(0, 63));
         go(ra, rn, 1'($urandom_range(0, 1)));
         wait_idle();
      end
      // asynchronous reset mid-SHIFT discards the operation
      acc = edges;
      go(32'hF0000000, 6'd20, 1'b0);
      while (edges < acc + 4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_c", c, 32'd0);
      check("mid_rst_flags", {28'd0, sticky, busy, done, 1'b0}, 32'd0);
      q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      go(32'hF0000000, 6'd4, 1'b0);
      wait_idle();
      repeat (2) @(negedge clk);
      check("queue_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
